// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment scanner: one digit per slot, frame-latched value,
// leading-zero blanking and 16-step PWM brightness via anode gating.
module seg_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic [3:0]              bright,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int STEP  = REFRESH_DIV / 16;
  localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(STEP - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF  = {8{ACTIVE_LOW}};

  if (REFRESH_DIV < 16 || (REFRESH_DIV % 16) != 0) begin : g_bad_refresh_div
    $fatal(1, "seg_display_scan: REFRESH_DIV must be >=16 and a multiple of 16");
  end

  // The slot counter is kept as {phase, sub}: phase is the PWM step, so no divider is needed.
  logic [SUB_W-1:0]        r_sub_cnt;
  logic [3:0]              r_phase;
  logic [DIG_W-1:0]        r_digit;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_frame_tick;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;

  logic                    w_sub_last;
  logic                    w_slot_last;
  logic                    w_frame_start;
  logic [NUM_DIGITS:0]     w_zero_from;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [3:0]              w_cur_nib;
  logic [6:0]              w_glyph;
  logic                    w_blank;
  logic                    w_dp;
  logic                    w_an_on;
  logic [7:0]              w_seg_ah;
  logic [NUM_DIGITS-1:0]   w_an_ah;

  assign w_sub_last    = (r_sub_cnt == SUB_LAST);
  assign w_slot_last   = w_sub_last && (r_phase == 4'hF);
  assign w_frame_start = (r_sub_cnt == '0) && (r_phase == 4'h0) && (r_digit == '0);

  // w_zero_from[i]: shadow nibbles i..NUM_DIGITS-1 are all zero.
  assign w_zero_from[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign w_nib[gi]       = r_shadow[4*gi +: 4];
    assign w_zero_from[gi] = w_zero_from[gi+1] && (r_shadow[4*gi +: 4] == 4'h0);
  end

  assign w_cur_nib = w_nib[r_digit];
  assign w_blank   = blank_lz && (r_digit != '0) && w_zero_from[r_digit];
  assign w_dp      = dp_mask[r_digit];
  assign w_an_on   = (r_phase <= bright) && (!w_blank || w_dp);
  assign w_seg_ah  = {w_dp, (w_blank ? 7'h00 : w_glyph)};
  assign w_an_ah   = w_an_on ? (NUM_DIGITS'(1) << r_digit) : '0;

  always_comb begin
    w_glyph = 7'h00;
    case (w_cur_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub_cnt    <= '0;
      r_phase      <= 4'h0;
      r_digit      <= '0;
      r_shadow     <= '0;
      r_frame_tick <= 1'b0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
    end else begin
      if (w_sub_last) begin
        r_sub_cnt <= '0;
        r_phase   <= r_phase + 4'h1;
      end else begin
        r_sub_cnt <= r_sub_cnt + 1'b1;
      end
      if (w_slot_last) begin
        r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
      end
      if (w_frame_start) begin
        r_shadow <= value;
      end
      r_frame_tick <= w_frame_start;
      r_an         <= w_an_ah ^ AN_OFF;
      r_seg        <= w_seg_ah ^ SEG_OFF;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan (4 digits, 16-clk slots, active-low):
// expected an/seg/frame_tick are queued before each edge and checked after it.
module tb_seg_display_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       tick;
    logic       chk_seg;
  } exp_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  bright;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(16),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .bright    (bright),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  task automatic push_exp(input logic [3:0] a, input logic [7:0] s, input logic t, input logic c);
    exp_t e;
    e.an = a; e.seg = s; e.tick = t; e.chk_seg = c;
    exp_q.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest queued expectation.
  task automatic cycle_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (an === e.an) else begin
      errors++;
      $error("FAIL %s an got %b exp %b", tag, an, e.an);
    end
    checks++;
    assert (frame_tick === e.tick) else begin
      errors++;
      $error("FAIL %s frame_tick got %b exp %b", tag, frame_tick, e.tick);
    end
    if (e.chk_seg) begin
      checks++;
      assert (seg === e.seg) else begin
        errors++;
        $error("FAIL %s seg got %h exp %h", tag, seg, e.seg);
      end
    end
    $display("%s an=%b seg=%h tick=%b", tag, an, seg, frame_tick);
  endtask

  // Check ncyc cycles of a frame, starting at its first displayed slot.
  // skip_first: the first cycle of a frame still shows the previous frame's digit 0.
  task automatic run_frame(input logic [15:0] shv, input int ncyc, input bit skip_first,
                           input int chg_at, input logic [15:0] new_val, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      int         d;
      int         ph;
      logic [3:0] nib;
      logic       bl;
      logic       dp;
      logic [7:0] s;
      logic [3:0] a;
      d   = i / 16;
      ph  = i % 16;
      nib = shv[4*d +: 4];
      bl  = blank_lz && (d != 0) && ((shv >> (4*d)) == 16'h0000);
      dp  = dp_mask[d];
      s   = ~{dp, (bl ? 7'h00 : GLYPH[nib])};
      a   = ((ph <= int'(bright)) && (!bl || dp)) ? ~(4'b0001 << d) : 4'hF;
      push_exp(a, s, (i == 0), !(skip_first && i == 0));
      cycle_check($sformatf("%s[%0d]", tag, i));
      if (i == chg_at) value = new_val;
    end
  endtask

  initial begin
    rst      = 1'b1;
    value    = 16'h1234;
    dp_mask  = 4'b0100;
    blank_lz = 1'b0;
    bright   = 4'd15;

    for (int i = 0; i < 3; i++) begin
      push_exp(4'hF, 8'hFF, 1'b0, 1'b1);
      cycle_check($sformatf("reset[%0d]", i));
    end
    rst = 1'b0;

    // Basic scan: 99,B0,24(dp),F9 at full brightness.
    run_frame(16'h1234, 64, 1'b1, -1, 16'h0, "scan_a");
    run_frame(16'h1234, 64, 1'b0, -1, 16'h0, "scan_b");

    // Mid-frame value change is held off until the next frame start.
    dp_mask = 4'b0000;
    run_frame(16'h1234, 64, 1'b0, 20, 16'hABCD, "tear_old");
    run_frame(16'hABCD, 64, 1'b1, -1, 16'h0, "tear_new");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    value    = 16'h0005;
    run_frame(16'h0005, 64, 1'b1, -1, 16'h0, "blank_5");
    value    = 16'h0000;
    run_frame(16'h0000, 64, 1'b1, -1, 16'h0, "blank_0");
    dp_mask  = 4'b1000;
    run_frame(16'h0000, 64, 1'b0, -1, 16'h0, "blank_dp");

    // PWM brightness.
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    value    = 16'h1234;
    bright   = 4'd3;
    run_frame(16'h1234, 64, 1'b1, -1, 16'h0, "pwm_3");
    bright   = 4'd0;
    run_frame(16'h1234, 64, 1'b0, -1, 16'h0, "pwm_0");
    bright   = 4'd15;
    run_frame(16'h1234, 64, 1'b0, -1, 16'h0, "pwm_15");

    // Reset pulse during digit 2 aborts the frame and restarts the scan.
    run_frame(16'h1234, 40, 1'b0, -1, 16'h0, "pre_rst");
    rst = 1'b1;
    push_exp(4'hF, 8'hFF, 1'b0, 1'b1);
    cycle_check("mid_rst");
    rst = 1'b0;
    run_frame(16'h1234, 64, 1'b1, -1, 16'h0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
